// File: rtl/trdb_pkg.sv
// Shared types for the trace encoder packet scheduler.
// Holds the packet format enums, scheduler FSM states, the emitter payload
// struct, pending-bit indices and the fixed-priority grant helper.
package trdb_pkg;

    localparam int unsigned FORMAT_W    = 2;
    localparam int unsigned SUBFORMAT_W = 2;
    localparam int unsigned NUM_REQ     = 4;

    // Pending-bit positions; higher index is higher priority.
    localparam int unsigned P_BMAP   = 0;
    localparam int unsigned P_ADDR   = 1;
    localparam int unsigned P_RESYNC = 2;
    localparam int unsigned P_SYNC   = 3;

    typedef enum logic [FORMAT_W-1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [SUBFORMAT_W-1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } trdb_sched_state_e;

    typedef struct packed {
        trdb_format_e           format;
        trdb_f_sync_subformat_e subformat;
    } trdb_emit_t;

    // One-hot grant of the highest pending bit: sync > resync > addr > bmap.
    function automatic logic [NUM_REQ-1:0] pick_grant(input logic [NUM_REQ-1:0] pend);
        logic [NUM_REQ-1:0] gnt;
        gnt = '0;
        if (pend[P_SYNC])        gnt[P_SYNC]   = 1'b1;
        else if (pend[P_RESYNC]) gnt[P_RESYNC] = 1'b1;
        else if (pend[P_ADDR])   gnt[P_ADDR]   = 1'b1;
        else if (pend[P_BMAP])   gnt[P_BMAP]   = 1'b1;
        return gnt;
    endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// Periodic resync counter.
// Counts accepted non-sync packets and flags a resync request when the count
// reaches resync_max_i; any accepted sync packet restarts the period and a
// zero period freezes the counter at 0.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   accept_i       : emitter handshake completed this cycle
//   is_sync_i      : accepted packet is format 3
//   resync_max_i   : accepted-packet period, 0 disables
//   resync_hit_c   : combinational, request a resync at this edge
module trdb_resync_counter
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                accept_i,
    input  logic                is_sync_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    output logic                resync_hit_c
);

    logic [RESYNC_W-1:0] cnt_q;
    logic [RESYNC_W-1:0] cnt_d;
    logic [RESYNC_W-1:0] cnt_inc;

    // Next count and hit detect.
    always_comb begin
        cnt_inc      = cnt_q + RESYNC_W'(1);
        cnt_d        = cnt_q;
        resync_hit_c = 1'b0;
        if (resync_max_i == '0) begin
            cnt_d = '0;
        end else if (accept_i) begin
            if (is_sync_i) begin
                cnt_d = '0;
            end else begin
                cnt_d        = cnt_inc;
                resync_hit_c = (cnt_inc == resync_max_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Trace encoder packet scheduler: latches packet requests, arbitrates them by
// fixed priority, forces a sync-start packet first after enable, inserts
// periodic resyncs and holds the emitter request under backpressure.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   enable_i               : trace enable, 0 forces OFF
//   req_sync_i/_sub_i      : format 3 request and its subformat
//   req_addr_i, req_bmap_i : format 2 / format 1 requests
//   resync_max_i           : accepted packets between resyncs, 0 disables
//   emit_ready_i           : emitter accepts current packet
//   emit_valid_o/format_o/subformat_o : registered packet request
//   drop_o, drop_cnt_o     : lost-request pulse and saturating count
//   busy_o                 : any request pending or in flight
module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_W = 16,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                req_sync_i,
    input  logic [1:0]          req_sync_sub_i,
    input  logic                req_addr_i,
    input  logic                req_bmap_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    input  logic                emit_ready_i,
    output logic                emit_valid_o,
    output logic [1:0]          emit_format_o,
    output logic [1:0]          emit_subformat_o,
    output logic                drop_o,
    output logic [DROP_W-1:0]   drop_cnt_o,
    output logic                busy_o
);

    trdb_sched_state_e      state_q, state_d;
    logic [NUM_REQ-1:0]     pend_q, pend_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    trdb_f_sync_subformat_e sync_sub_q, sync_sub_d;
    trdb_emit_t             emit_q, emit_d;
    logic                   valid_q, valid_d;
    logic                   drop_q, drop_d;
    logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic                   resync_hit_c;
    logic [NUM_REQ-1:0]     clr;
    logic [NUM_REQ-1:0]     kept;
    logic [NUM_REQ-1:0]     ext_req;
    logic [NUM_REQ-1:0]     drops;
    logic [NUM_REQ-1:0]     sel;

    assign accept = valid_q & emit_ready_i;

    trdb_resync_counter #(
        .RESYNC_W (RESYNC_W)
    ) u_resync (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .accept_i     (accept),
        .is_sync_i    (emit_q.format == F_SYNC),
        .resync_max_i (resync_max_i),
        .resync_hit_c (resync_hit_c)
    );

    // Request bookkeeping: a new request on a still-pending, uncleared bit is lost.
    always_comb begin
        clr     = (state_q == HOLD && accept) ? gnt_q : '0;
        kept    = pend_q & ~clr;
        ext_req = '0;
        ext_req[P_SYNC] = req_sync_i;
        ext_req[P_ADDR] = req_addr_i;
        ext_req[P_BMAP] = req_bmap_i;
        drops   = ext_req & kept;
        sel     = pick_grant(pend_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        pend_d     = kept | ext_req;
        pend_d[P_RESYNC] = kept[P_RESYNC] | resync_hit_c;
        gnt_d      = gnt_q;
        sync_sub_d = sync_sub_q;
        emit_d     = emit_q;
        valid_d    = valid_q;
        drop_d     = |drops;
        drop_cnt_d = drop_cnt_q;

        // The newer sync request only sets the subformat if it is not dropped.
        if (req_sync_i && !kept[P_SYNC]) begin
            sync_sub_d = trdb_f_sync_subformat_e'(req_sync_sub_i);
        end
        if ((|drops) && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end

        unique case (state_q)
            OFF: begin
                valid_d = 1'b0;
                state_d = START;
                valid_d = 1'b1;
                emit_d  = '{format: F_SYNC, subformat: SF_START};
                gnt_d   = '0;
            end
            START: begin
                if (accept) begin
                    state_d = RUN;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                if (|pend_q) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    gnt_d   = sel;
                    if (sel[P_SYNC])        emit_d = '{format: F_SYNC,       subformat: sync_sub_q};
                    else if (sel[P_RESYNC]) emit_d = '{format: F_SYNC,       subformat: SF_START};
                    else if (sel[P_ADDR])   emit_d = '{format: F_ADDR_ONLY,  subformat: SF_START};
                    else                    emit_d = '{format: F_DIFF_DELTA, subformat: SF_START};
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = RUN;
                    valid_d = 1'b0;
                    gnt_d   = '0;
                end
            end
            default: state_d = OFF;
        endcase

        // Disable overrides everything except the drop count.
        if (!enable_i) begin
            state_d    = OFF;
            pend_d     = '0;
            gnt_d      = '0;
            valid_d    = 1'b0;
            emit_d     = '{format: F_OPT_EXT, subformat: SF_START};
            drop_d     = 1'b0;
            drop_cnt_d = drop_cnt_q;
            sync_sub_d = sync_sub_q;
        end

        busy_d = (|pend_d) | valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= OFF;
            pend_q     <= '0;
            gnt_q      <= '0;
            sync_sub_q <= SF_START;
            emit_q     <= '{format: F_OPT_EXT, subformat: SF_START};
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            gnt_q      <= gnt_d;
            sync_sub_q <= sync_sub_d;
            emit_q     <= emit_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign emit_valid_o     = valid_q;
    assign emit_format_o    = emit_q.format;
    assign emit_subformat_o = emit_q.subformat;
    assign drop_o           = drop_q;
    assign drop_cnt_o       = drop_cnt_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed self-checking bench for trdb_packet_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trdb_packet_scheduler;

    localparam int unsigned RESYNC_W = 16;
    localparam int unsigned DROP_W   = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                enable_i;
    logic                req_sync_i;
    logic [1:0]          req_sync_sub_i;
    logic                req_addr_i;
    logic                req_bmap_i;
    logic [RESYNC_W-1:0] resync_max_i;
    logic                emit_ready_i;
    logic                emit_valid_o;
    logic [1:0]          emit_format_o;
    logic [1:0]          emit_subformat_o;
    logic                drop_o;
    logic [DROP_W-1:0]   drop_cnt_o;
    logic                busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    trdb_packet_scheduler #(
        .RESYNC_W (RESYNC_W),
        .DROP_W   (DROP_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .enable_i         (enable_i),
        .req_sync_i       (req_sync_i),
        .req_sync_sub_i   (req_sync_sub_i),
        .req_addr_i       (req_addr_i),
        .req_bmap_i       (req_bmap_i),
        .resync_max_i     (resync_max_i),
        .emit_ready_i     (emit_ready_i),
        .emit_valid_o     (emit_valid_o),
        .emit_format_o    (emit_format_o),
        .emit_subformat_o (emit_subformat_o),
        .drop_o           (drop_o),
        .drop_cnt_o       (drop_cnt_o),
        .busy_o           (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Wait (bounded) for a packet, check it, accept it and check valid drops.
    task automatic expect_pkt(input string tag, input logic [1:0] fmt, input logic [1:0] sub);
        int n;
        n = 0;
        while (!emit_valid_o && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(emit_valid_o), 32'd1);
        check({tag, "_fmt"},   32'(emit_format_o), 32'(fmt));
        check({tag, "_sub"},   32'(emit_subformat_o), 32'(sub));
        emit_ready_i = 1'b1;
        tick();
        emit_ready_i = 1'b0;
        check({tag, "_gap"}, 32'(emit_valid_o), 32'd0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        enable_i       = 1'b0;
        req_sync_i     = 1'b0;
        req_sync_sub_i = 2'd0;
        req_addr_i     = 1'b0;
        req_bmap_i     = 1'b0;
        resync_max_i   = '0;
        emit_ready_i   = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_valid", 32'(emit_valid_o), 32'd0);
        check("rst_fmt",   32'(emit_format_o), 32'd0);
        check("rst_sub",   32'(emit_subformat_o), 32'd0);
        check("rst_drop",  32'(drop_o), 32'd0);
        check("rst_cnt",   32'(drop_cnt_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);

        // First packet after enable is sync start.
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        tick();
        check("start_busy", 32'(busy_o), 32'd1);
        expect_pkt("start", 2'd3, 2'd0);
        check("start_idle", 32'(busy_o), 32'd0);

        // Simultaneous requests issue in priority order.
        req_bmap_i = 1'b1; req_addr_i = 1'b1; req_sync_i = 1'b1; req_sync_sub_i = 2'd1;
        tick();
        req_bmap_i = 1'b0; req_addr_i = 1'b0; req_sync_i = 1'b0; req_sync_sub_i = 2'd0;
        expect_pkt("ord_sync", 2'd3, 2'd1);
        expect_pkt("ord_addr", 2'd2, 2'd0);
        expect_pkt("ord_bmap", 2'd1, 2'd0);
        check("ord_idle", 32'(busy_o), 32'd0);

        // Backpressure: outputs stable for 5 cycles.
        req_addr_i = 1'b1;
        tick();
        req_addr_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(emit_valid_o), 32'd1);
            check("bp_fmt",   32'(emit_format_o), 32'd2);
            tick();
        end
        expect_pkt("bp", 2'd2, 2'd0);
        check("bp_idle", 32'(busy_o), 32'd0);

        // Second addr request while the first is pending is dropped.
        req_addr_i = 1'b1;
        tick();
        req_addr_i = 1'b0;
        check("drop_none", 32'(drop_o), 32'd0);
        req_addr_i = 1'b1;
        tick();
        req_addr_i = 1'b0;
        check("drop_pulse", 32'(drop_o), 32'd1);
        check("drop_cnt1",  32'(drop_cnt_o), 32'd1);
        tick();
        check("drop_end", 32'(drop_o), 32'd0);
        expect_pkt("drop_f2", 2'd2, 2'd0);
        tick();
        tick();
        check("drop_single", 32'(emit_valid_o), 32'd0);
        check("drop_idle",   32'(busy_o), 32'd0);

        // 300 cycles of addr requests: 299 more drops, counter saturates.
        req_addr_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        req_addr_i = 1'b0;
        check("drop_sat", 32'(drop_cnt_o), 32'd255);
        expect_pkt("sat_f2", 2'd2, 2'd0);
        check("sat_keep", 32'(drop_cnt_o), 32'd255);

        // A request arriving with the grant-clear of its bit stays pending.
        req_addr_i = 1'b1;
        tick();
        req_addr_i = 1'b0;
        tick();
        check("setwin_hold", 32'(emit_valid_o), 32'd1);
        emit_ready_i = 1'b1;
        req_addr_i   = 1'b1;
        tick();
        emit_ready_i = 1'b0;
        req_addr_i   = 1'b0;
        check("setwin_nodrop", 32'(drop_o), 32'd0);
        check("setwin_busy",   32'(busy_o), 32'd1);
        expect_pkt("setwin_f2", 2'd2, 2'd0);

        // Resync after four accepted format 1 packets.
        resync_max_i = 16'd4;
        for (int i = 0; i < 4; i++) begin
            req_bmap_i = 1'b1;
            tick();
            req_bmap_i = 1'b0;
            expect_pkt("rs_bmap", 2'd1, 2'd0);
            check("rs_busy", 32'(busy_o), (i == 3) ? 32'd1 : 32'd0);
        end
        expect_pkt("rs_sync", 2'd3, 2'd0);
        check("rs_idle", 32'(busy_o), 32'd0);

        // Zero period: no resync after 20 packets.
        resync_max_i = '0;
        for (int i = 0; i < 20; i++) begin
            req_bmap_i = 1'b1;
            tick();
            req_bmap_i = 1'b0;
            expect_pkt("nors_bmap", 2'd1, 2'd0);
        end
        tick();
        tick();
        check("nors_valid", 32'(emit_valid_o), 32'd0);
        check("nors_busy",  32'(busy_o), 32'd0);

        // Disable during HOLD with bmap still pending.
        req_addr_i = 1'b1; req_bmap_i = 1'b1;
        tick();
        req_addr_i = 1'b0; req_bmap_i = 1'b0;
        tick();
        check("dis_hold_fmt", 32'(emit_format_o), 32'd2);
        enable_i = 1'b0;
        tick();
        check("dis_valid", 32'(emit_valid_o), 32'd0);
        check("dis_busy",  32'(busy_o), 32'd0);
        check("dis_cnt",   32'(drop_cnt_o), 32'd255);
        tick();
        enable_i = 1'b1;
        tick();
        expect_pkt("reen_start", 2'd3, 2'd0);
        tick();
        check("reen_idle", 32'(busy_o), 32'd0);

        // Reset in HOLD discards the packet.
        req_addr_i = 1'b1;
        tick();
        req_addr_i = 1'b0;
        tick();
        check("rsth_valid", 32'(emit_valid_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        check("rsth_drop_valid", 32'(emit_valid_o), 32'd0);
        check("rsth_busy",       32'(busy_o), 32'd0);
        check("rsth_cnt",        32'(drop_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
